// File: rtl/des_iter_round_ctrl.sv
// des_iter_round_ctrl: iterative DES controller, one Feistel round per clock with an external f(R,K).
module des_iter_round_ctrl #(
    parameter bit BYPASS_PERM = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic [31:0] f_r,
    output logic [47:0] f_k,
    input  logic [31:0] f_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [3:0]  round_idx
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] l, r;
    logic [27:0] c, d, cn, dn;
    logic [1:0]  sh;
    logic [3:0]  cnt;
    logic        dir;

    // Tables use FIPS numbering (bit 1 = MSB); outputs are shifted in MSB first.
    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
        return BYPASS_PERM ? x : y;
    endfunction

    // FP is the inverse of IP, so scatter through the same table.
    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
        return BYPASS_PERM ? x : y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
        return y;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] n, input logic right);
        return right ? (n == 2'd0 ? x : n == 2'd1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]})
                     : (n == 2'd1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]});
    endfunction

    // Decrypt starts with a zero shift so round 1 sees the round-16 encrypt subkey.
    always_comb begin
        sh = (cnt == 4'd0) ? (dir ? 2'd0 : 2'd1)
           : (cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) ? 2'd1 : 2'd2;
        cn = rot(c, sh, dir);
        dn = rot(d, sh, dir);
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign round_idx = (state == ROUND) ? cnt : 4'd0;
    assign f_r       = (state == ROUND) ? r : 32'd0;
    assign f_k       = (state == ROUND) ? pc2({cn, dn}) : 48'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            dir       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {l, r}   <= ip(in_data);
                    {c, d}   <= pc1(in_key);
                    dir      <= in_decrypt;
                    cnt      <= '0;
                    state    <= ROUND;
                end
                ROUND: begin
                    c   <= cn;
                    d   <= dn;
                    l   <= r;
                    r   <= l ^ f_out;
                    cnt <= cnt + 4'd1;
                    // Last round: halves are swapped before FP; cnt wraps back to 0.
                    if (cnt == 4'd15) begin
                        out_data  <= fp({l ^ f_out, r});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_iter_round_ctrl.sv
// tb_des_iter_round_ctrl: drives the DES controller with a behavioural f() and compares against a textbook DES model.
module tb_des_iter_round_ctrl;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [63:0] in_data = '0, in_key = '0, out_data;
    logic [31:0] f_r, f_out;
    logic [47:0] f_k;
    logic [3:0]  round_idx;
    int          total = 0, bad = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT   = 64'h85E813540F0AB405;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [31:0] des_f(input logic [31:0] rr, input logic [47:0] kk);
        logic [47:0] x;
        logic [31:0] s, p;
        logic [5:0]  b;
        x = '0;
        for (int i = 0; i < 48; i++) x = {x[46:0], rr[5'(32 - E_T[i])]};
        x = x ^ kk;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[6'(47 - 6 * j) -: 6];
            s = {s[27:0], 4'(SB[{3'(j), b[5], b[0], b[4:1]}])};
        end
        p = '0;
        for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P_T[i])]};
        return p;
    endfunction

    // Subkey K_n (n = 1..16) by the classic cumulative left-shift schedule.
    function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [47:0] k;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - PC1_T[i])]};
        for (int j = 0; j < n; j++)
            for (int s = 0; s < SHIFTS[j]; s++) cd = {cd[54:28], cd[55], cd[26:0], cd[27]};
        k = '0;
        for (int i = 0; i < 48; i++) k = {k[46:0], cd[6'(56 - PC2_T[i])]};
        return k;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] key, input logic dec);
        logic [63:0] t, o;
        logic [31:0] l, r, nl;
        t = '0;
        for (int i = 0; i < 64; i++) t = {t[62:0], blk[6'(64 - IP_T[i])]};
        l = t[63:32];
        r = t[31:0];
        for (int n = 1; n <= 16; n++) begin
            nl = r;
            r  = l ^ des_f(r, subkey(key, dec ? 17 - n : n));
            l  = nl;
        end
        t = {r, l};
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(64 - IP_T[i])] = t[6'(63 - i)];
        return o;
    endfunction

    assign f_out = des_f(f_r, f_k);

    always #5 clk = ~clk;

    des_iter_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .in_decrypt(in_decrypt), .f_r(f_r), .f_k(f_k), .f_out(f_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .round_idx(round_idx)
    );

    // Offers one block, scrambles inputs after accept, records round-1/16 subkeys and latency.
    task automatic run_block(input logic [63:0] data, input logic [63:0] key, input logic dec, input int hold,
                             output logic [63:0] res, output logic [47:0] k1, output logic [47:0] k16,
                             output int lat, output int idx_err);
        @(negedge clk);
        in_valid = 1'b1; in_data = data; in_key = key; in_decrypt = dec;
        @(posedge clk);
        #1 in_valid = 1'b0; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom}; in_decrypt = ~dec;
        lat = -1; idx_err = 0; k1 = 'x; k16 = 'x;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
            else begin
                if (round_idx !== 4'(k)) idx_err++;
                if (k == 0) k1 = f_k;
                if (k == 15) k16 = f_k;
            end
        end
        res = out_data;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        total++; if (out_data !== 64'd0) begin bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL rst_round_idx got %0d want 0", round_idx); end
        total++; if (f_r !== 32'd0 || f_k !== 48'd0) begin bad++; $display("FAIL rst_f_ports got %h/%h want 0/0", f_r, f_k); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_valid_ignored busy got %b want 0", busy); end
    endtask

    task automatic test_fips_enc();
        logic [63:0] res; logic [47:0] k1, k16; int lat, ie;
        run_block(PT, KEY, 1'b0, 0, res, k1, k16, lat, ie);
        total++; if (res !== CT) begin bad++; $display("FAIL enc_out got %h want %h", res, CT); end
        total++; if (k1 !== K1) begin bad++; $display("FAIL enc_k1 got %h want %h", k1, K1); end
        total++; if (k16 !== K16) begin bad++; $display("FAIL enc_k16 got %h want %h", k16, K16); end
        total++; if (lat !== 16) begin bad++; $display("FAIL enc_latency got %0d want 16 edges after accept", lat); end
        total++; if (ie !== 0) begin bad++; $display("FAIL enc_round_idx got %0d bad rounds want 0", ie); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL enc_release got v=%b r=%b want 0/1", out_valid, in_ready); end
        total++; if (out_data !== CT) begin bad++; $display("FAIL enc_retain got %h want %h", out_data, CT); end
    endtask

    task automatic test_fips_dec();
        logic [63:0] res; logic [47:0] k1, k16; int lat, ie;
        run_block(CT, KEY, 1'b1, 0, res, k1, k16, lat, ie);
        total++; if (res !== PT) begin bad++; $display("FAIL dec_out got %h want %h", res, PT); end
        total++; if (k1 !== K16) begin bad++; $display("FAIL dec_k1 got %h want %h", k1, K16); end
        total++; if (k16 !== K1) begin bad++; $display("FAIL dec_k16 got %h want %h", k16, K1); end
        total++; if (lat !== 16) begin bad++; $display("FAIL dec_latency got %0d want 16", lat); end
    endtask

    task automatic test_known_answer();
        logic [63:0] res; logic [47:0] k1, k16; int lat, ie;
        run_block(64'd0, 64'd0, 1'b0, 1, res, k1, k16, lat, ie);
        total++; if (res !== 64'h8CA64DE9C1B123A7) begin bad++; $display("FAIL kat_enc got %h want 8ca64de9c1b123a7", res); end
        run_block(64'h8CA64DE9C1B123A7, 64'd0, 1'b1, 2, res, k1, k16, lat, ie);
        total++; if (res !== 64'd0) begin bad++; $display("FAIL kat_dec got %h want 0", res); end
    endtask

    task automatic test_parity();
        logic [63:0] res; logic [47:0] k1, k16; int lat, ie;
        run_block(PT, KEY ^ 64'h0101010101010101, 1'b0, 0, res, k1, k16, lat, ie);
        total++; if (res !== CT) begin bad++; $display("FAIL parity_out got %h want %h", res, CT); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, ka, b, kb, held;
        int k, err, lat;
        a = {$urandom, $urandom}; ka = {$urandom, $urandom};
        b = {$urandom, $urandom}; kb = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1; in_data = a; in_key = ka; in_decrypt = 1'b0;
        @(posedge clk);
        #1 in_data = b; in_key = kb; in_decrypt = 1'b1;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        total++; if (out_valid !== 1'b1 || out_data !== des_model(a, ka, 1'b0)) begin bad++; $display("FAIL bp_first got %h want %h", out_data, des_model(a, ka, 1'b0)); end
        held = out_data; err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", err); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== held) begin bad++; $display("FAIL bp_release got v=%b r=%b d=%h want 0/1/%h", out_valid, in_ready, out_data, held); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int j = 0; j < 40 && lat < 0; j++) begin @(negedge clk); if (out_valid) lat = j; end
        total++; if (lat !== 16) begin bad++; $display("FAIL bp_second_latency got %0d want 16", lat); end
        total++; if (out_data !== des_model(b, kb, 1'b1)) begin bad++; $display("FAIL bp_second got %h want %h", out_data, des_model(b, kb, 1'b1)); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; logic [47:0] k1, k16; int lat, ie, k, seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom}; in_decrypt = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (round_idx !== 4'd6 && k < 40) begin @(negedge clk); k++; end
        total++; if (round_idx !== 4'd6) begin bad++; $display("FAIL mid_reach got round %0d want 6", round_idx); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || round_idx !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_state got r=%b v=%b idx=%0d b=%b want 1/0/0/0", in_ready, out_valid, round_idx, busy); end
        seen = 0;
        repeat (20) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_output got %0d valid cycles want 0", seen); end
        run_block(PT, KEY, 1'b0, 0, res, k1, k16, lat, ie);
        total++; if (res !== CT) begin bad++; $display("FAIL mid_after got %h want %h", res, CT); end
    endtask

    task automatic test_random();
        logic [63:0] data, key, res, exp; logic [47:0] k1, k16; logic dec; int lat, ie;
        for (int n = 0; n < 24; n++) begin
            data = {$urandom, $urandom}; key = {$urandom, $urandom}; dec = 1'($urandom_range(1));
            run_block(data, key, dec, int'($urandom_range(3)), res, k1, k16, lat, ie);
            exp = des_model(data, key, dec);
            total++; if (res !== exp) begin bad++; $display("FAIL rand_out[%0d] got %h want %h", n, res, exp); end
            total++; if (k1 !== subkey(key, dec ? 16 : 1) || k16 !== subkey(key, dec ? 1 : 16)) begin bad++; $display("FAIL rand_subkey[%0d] got %h/%h want %h/%h", n, k1, k16, subkey(key, dec ? 16 : 1), subkey(key, dec ? 1 : 16)); end
            total++; if (lat !== 16) begin bad++; $display("FAIL rand_latency[%0d] got %0d want 16", n, lat); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fips_enc();
        test_fips_dec();
        test_known_answer();
        test_parity();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
